latch_bank_wr_ctrl: RTL

Write controller and arbiter for a bank of transparent D latches (`d_latch` cells with D/En inputs and Q/Qc outputs). It shares one latch data bus among several requesters. It sequences each write as setup, enable pulse and hold, so that D is stable before En rises and after En falls. It sits between synchronous requesters and the latch array, and is the only block that drives latch D/En.

---
 rtl/latch_ctrl_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/latch_bank_wr_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/latch_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | latch_ctrl_pkg : shared states and defaults for latch write ctrl   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package latch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_ADDR_W    = 2;
    localparam int DEF_PULSE_CYC = 2;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +--------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick starting at ptr        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
    import latch_ctrl_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int IDX_W = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  win,
    output logic [IDX_W-1:0] win_idx
);

    logic [IDX_W-1:0] w_j;
    logic             w_found;

    always_comb begin
        win     = '0;
        win_idx = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = IDX_W'((int'(ptr) + k) % NREQ);
            if (!w_found && req[w_j]) begin
                w_found    = 1'b1;
                win[w_j]   = 1'b1;
                win_idx    = w_j;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/latch_bank_wr_ctrl.sv
// +--------------------------------------------------------------------+
// | latch_bank_wr_ctrl : arbitrated setup/pulse/hold writer for a      |
// | bank of transparent latches.  Rev 1.0                              |
// +--------------------------------------------------------------------+
`default_nettype none

module latch_bank_wr_ctrl
    import latch_ctrl_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int PULSE_CYC = DEF_PULSE_CYC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [WIDTH-1:0]         lat_d,
    output logic [(2**ADDR_W)-1:0]   lat_en,
    output logic                     busy
);

    localparam int IDX_W = clog2_min1(NREQ);
    localparam int NLAT  = 2**ADDR_W;
    localparam int CNT_W = clog2_min1(PULSE_CYC);

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]  r_addr;
    logic [WIDTH-1:0]   r_data;
    logic [CNT_W-1:0]   r_cnt;

    logic [NREQ-1:0]    w_win;
    logic [IDX_W-1:0]   w_idx;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [WIDTH-1:0]   w_sel_data;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (req),
        .ptr     (r_ptr),
        .win     (w_win),
        .win_idx (w_idx)
    );

    assign w_sel_addr = req_addr[w_idx*ADDR_W +: ADDR_W];
    assign w_sel_data = req_data[w_idx*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
            gnt     <= '0;
            done    <= '0;
            lat_d   <= '0;
            lat_en  <= '0;
            busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // D is driven during SETUP so it leads En by a full clock.
                    if (|req) begin
                        r_addr  <= w_sel_addr;
                        r_data  <= w_sel_data;
                        lat_d   <= w_sel_data;
                        gnt     <= w_win;
                        busy    <= 1'b1;
                        r_ptr   <= (w_idx == IDX_W'(NREQ-1)) ? '0 : w_idx + 1'b1;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    lat_d   <= r_data;
                    lat_en  <= NLAT'(1) << r_addr;
                    r_cnt   <= CNT_W'(PULSE_CYC-1);
                    r_state <= ST_PULSE;
                end
                ST_PULSE: begin
                    if (r_cnt == '0) begin
                        lat_en  <= '0;
                        done    <= gnt;
                        r_state <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    done    <= '0;
                    gnt     <= '0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
